tick_timer: RTL and testbench

//   Programmable down-counting event timer downstream of the ring timer: counts

---
 rtl/tick_timer.sv | 119 +++++++++++
 tb/tb_tick_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable down-counting tick timer: one-shot or periodic expiry, sticky irq with ack.
// Optional build macro TICK_TIMER_EDGE_EN counts rising edges of tick instead of high cycles.
module tick_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] period,
   input  logic         periodic,
   input  logic         start,
   input  logic         stop,
   input  logic         ack,
   output logic [W-1:0] count,
   output logic         running,
   output logic         expired,
   output logic         irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = '0;

   state_t         state_q;
   logic [W-1:0]   count_q;
   logic [W-1:0]   reload_q;
   logic           expired_q;
   logic           irq_q;
   logic           ev_s;
   logic           expiry_s;

`ifdef TICK_TIMER_EDGE_EN
   logic tick_q;

   // Previous tick level for rising-edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick;
      end
   end

   assign ev_s = tick & ~tick_q;
`else
   assign ev_s = tick;
`endif

   // stop and start both mask the counted event in the same cycle.
   assign expiry_s = ev_s & ~stop & ~start & (state_q == ST_RUN) & (count_q == ONE);

   // Timer state machine, counter, reload register and flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         count_q   <= ZERO;
         reload_q  <= ZERO;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         expired_q <= expiry_s;

         if (load) begin
            reload_q <= period;
         end else begin
            reload_q <= reload_q;
         end

         // Loading while idle also presets the visible count; start below may override it.
         if (load && (state_q == ST_IDLE)) begin
            count_q <= period;
         end else begin
            count_q <= count_q;
         end

         if (stop) begin
            state_q <= ST_IDLE;
         end else if (start) begin
            if (reload_q != ZERO) begin
               count_q <= reload_q;
               state_q <= ST_RUN;
            end else begin
               state_q <= state_q;
            end
         end else if (ev_s && (state_q == ST_RUN)) begin
            if (count_q > ONE) begin
               count_q <= count_q - ONE;
            end else if (periodic && (reload_q != ZERO)) begin
               count_q <= reload_q;
            end else begin
               count_q <= ZERO;
               state_q <= ST_DONE;
            end
         end else begin
            state_q <= state_q;
         end

         if (expiry_s) begin
            irq_q <= 1'b1;
         end else if (ack) begin
            irq_q <= 1'b0;
         end else begin
            irq_q <= irq_q;
         end
      end
   end

   assign count   = count_q;
   assign running = (state_q == ST_RUN);
   assign expired = expired_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus random stimulus against a cycle model.
module tb_tick_timer;
   localparam int W = 8;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;

   logic         clock = 1'b0;
   logic         clk_en = 1'b1;
   logic         reset_n = 1'b0;
   logic         tick = 1'b0, load = 1'b0, periodic = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
   logic [W-1:0] period = '0;
   logic [W-1:0] count;
   logic         running, expired, irq;

   int checks = 0;
   int failures = 0;

   int m_state, m_count, m_reload, m_expired, m_irq, m_tick_prev;

   tick_timer #(.W(W)) dut (
      .clock(clock), .reset_n(reset_n), .tick(tick), .load(load), .period(period),
      .periodic(periodic), .start(start), .stop(stop), .ack(ack),
      .count(count), .running(running), .expired(expired), .irq(irq)
   );

   always begin
      #5;
      if (clk_en) clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_count = 0; m_reload = 0; m_expired = 0; m_irq = 0; m_tick_prev = 0;
   endtask

   // Reference behaviour for one rising clock edge, using the current inputs.
   task automatic model_step();
      int  old_reload;
      bit  ev;
`ifdef TICK_TIMER_EDGE_EN
      ev = tick && (m_tick_prev == 0);
`else
      ev = tick;
`endif
      m_tick_prev = tick;
      old_reload  = m_reload;
      m_expired   = 0;
      if (load) m_reload = period;
      if (load && m_state == S_IDLE) m_count = period;
      if (stop) begin
         m_state = S_IDLE;
      end else if (start) begin
         if (old_reload != 0) begin
            m_count = old_reload;
            m_state = S_RUN;
         end
      end else if (ev && m_state == S_RUN) begin
         m_count = m_count - 1;
         if (m_count == 0) begin
            m_expired = 1;
            if (periodic && old_reload != 0) m_count = old_reload;
            else m_state = S_DONE;
         end
      end
      if (m_expired) m_irq = 1;
      else if (ack) m_irq = 0;
   endtask

   task automatic compare_model();
      check_eq("count", count, m_count);
      check_eq("running", running, (m_state == S_RUN) ? 1 : 0);
      check_eq("expired", expired, m_expired);
      check_eq("irq", irq, m_irq);
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_model();
   endtask

   task automatic clear_inputs();
      tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
   endtask

   task automatic reset_dut();
      reset_n = 1'b0;
      clear_inputs();
      model_reset();
      #3;
      check_eq("rst_count", count, 0);
      check_eq("rst_running", running, 0);
      check_eq("rst_expired", expired, 0);
      check_eq("rst_irq", irq, 0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   int exp_c[6] = '{2, 1, 3, 2, 1, 3};
   int exp_e[6] = '{0, 0, 1, 0, 0, 1};

   initial begin
      model_reset();
      #12;
      reset_dut();

      // Periodic reload every 3 ticks.
      period = 8'd3; periodic = 1'b1; load = 1'b1; cycle();
      load = 1'b0; start = 1'b1; cycle();
      start = 1'b0;
      check_eq("t1_start_count", count, 3);
      check_eq("t1_running", running, 1);
      for (int i = 0; i < 6; i++) begin
         tick = 1'b1; cycle();
         check_eq("t1_count", count, exp_c[i]);
         check_eq("t1_expired", expired, exp_e[i]);
         tick = 1'b0; cycle();
         check_eq("t1_expired_low", expired, 0);
      end
      check_eq("t1_irq", irq, 1);

      // stop beats start in the same cycle.
      tick = 1'b1; cycle(); tick = 1'b0;
      check_eq("t3_pre_count", count, 2);
      stop = 1'b1; start = 1'b1; cycle();
      stop = 1'b0; start = 1'b0;
      check_eq("t3_running", running, 0);
      check_eq("t3_count", count, 2);

      // Zero period: start ignored.
      reset_dut();
      period = 8'd0; load = 1'b1; cycle();
      load = 1'b0; start = 1'b1; cycle();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick = ~tick; cycle();
         check_eq("t4_running", running, 0);
         check_eq("t4_expired", expired, 0);
      end
      tick = 1'b0;

      // One-shot expiry with ack on the expiring cycle.
      period = 8'd2; periodic = 1'b0; load = 1'b1; cycle();
      load = 1'b0; start = 1'b1; cycle();
      start = 1'b0; tick = 1'b1; cycle();
      tick = 1'b0; cycle();
      check_eq("t5_count1", count, 1);
      tick = 1'b1; ack = 1'b1; cycle();
      check_eq("t5_expired", expired, 1);
      check_eq("t5_irq_kept", irq, 1);
      check_eq("t5_done_count", count, 0);
      check_eq("t5_done_running", running, 0);
      tick = 1'b0; ack = 1'b0; cycle();
      check_eq("t2_irq_held", irq, 1);
      check_eq("t2_expired_once", expired, 0);
      ack = 1'b1; cycle();
      ack = 1'b0;
      check_eq("t5_irq_cleared", irq, 0);

      // Held tick level.
      reset_dut();
      period = 8'd8; load = 1'b1; cycle();
      load = 1'b0; start = 1'b1; cycle();
      start = 1'b0; tick = 1'b1;
      repeat (5) cycle();
      tick = 1'b0; cycle();
`ifdef TICK_TIMER_EDGE_EN
      check_eq("t7_count", count, 7);
`else
      check_eq("t7_count", count, 3);
`endif

      // Asynchronous reset with the clock stopped mid-run.
      check_eq("t6_pre_running", running, 1);
      clk_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_eq("t6_count", count, 0);
      check_eq("t6_running", running, 0);
      check_eq("t6_irq", irq, 0);
      check_eq("t6_expired", expired, 0);
      model_reset();
      #4 reset_n = 1'b1;
      #2 clk_en = 1'b1;
      @(negedge clock);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         tick  = ($urandom_range(0, 1) == 1);
         load  = ($urandom_range(0, 9) == 0);
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 31) == 0);
         ack   = ($urandom_range(0, 5) == 0);
         period = W'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) periodic = ~periodic;
         cycle();
      end
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
